// File: rtl/car_motion_controller.sv
// car_motion_controller
//   Per-car SCAN (collective) motion and door controller for a 7-floor shaft.
//   Hall calls arrive already assigned to this car. Cabin calls are latched
//   here. The car sweeps in one direction while requests remain ahead, then
//   reverses.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   hallButton[13:0]: assigned hall calls, floor k -> {UP=bit 2k-1, DOWN=bit 2k-2}
//   carButton[6:0]  : cabin call pulses, bit k-1 = floor k
//   currentFloor    : 1..7
//   direction       : STOP=00, UP=10, DOWN=01
//   doorOpen        : high while the door dwell runs
//   servedButton    : one-cycle pulse of hall bits served on door entry
//   carCallPending  : latched cabin calls
module car_motion_controller #(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] hallButton,
  input  logic [6:0]  carButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  direction,
  output logic        doorOpen,
  output logic [13:0] servedButton,
  output logic [6:0]  carCallPending
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DN   = 2'b01;

  localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

  // DOWN at floor 1 and UP at floor 7 do not exist.
  localparam logic [13:0] HALL_VALID = 14'h1FFE;

  state_e          state_q, state_d;
  logic [2:0]      floor_q, floor_d;
  logic [1:0]      dir_q, dir_d;
  logic [CW-1:0]   move_cnt_q, move_cnt_d;
  logic [CW-1:0]   door_cnt_q, door_cnt_d;
  logic [13:0]     served_q, served_d;
  logic [6:0]      ccp_q, ccp_d;

  logic [13:0]     hv;
  logic [7:0]      req;        // req[k] = any request at floor k; req[0] unused
  logic [2:0]      nf;         // floor being arrived at
  logic            stop;

  // Requests strictly above / below floor f.
  function automatic logic above_of(input logic [7:0] r, input logic [2:0] f);
    return |(r & (8'hFF << ({1'b0, f} + 4'd1)));
  endfunction

  function automatic logic below_of(input logic [7:0] r, input logic [2:0] f);
    return |(r & ((8'd1 << f) - 8'd1) & 8'hFE);
  endfunction

  function automatic logic hall_up(input logic [13:0] h, input logic [2:0] f);
    return h[{f, 1'b0} - 4'd1];
  endfunction

  function automatic logic hall_dn(input logic [13:0] h, input logic [2:0] f);
    return h[{f, 1'b0} - 4'd2];
  endfunction

  function automatic logic [13:0] floor_mask(input logic [2:0] f);
    return 14'b11 << ({f, 1'b0} - 4'd2);
  endfunction

  assign hv = hallButton & HALL_VALID;

  always_comb begin
    req = '0;
    for (int k = 1; k <= 7; k++)
      req[k] = ccp_q[k-1] | hv[2*k-1] | hv[2*k-2];
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    served_d   = '0;
    ccp_d      = ccp_q | carButton;
    nf         = floor_q;
    stop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req[floor_q]) begin
          // Door opens in place; direction stays STOP.
          state_d                 = S_DOOR;
          door_cnt_d              = DOOR_LOAD;
          served_d                = hv & floor_mask(floor_q);
          ccp_d[floor_q - 3'd1]   = 1'b0;
        end else if (above_of(req, floor_q)) begin
          state_d    = S_MOVE;
          dir_d      = DIR_UP;
          move_cnt_d = MOVE_LOAD;
        end else if (below_of(req, floor_q)) begin
          state_d    = S_MOVE;
          dir_d      = DIR_DN;
          move_cnt_d = MOVE_LOAD;
        end
      end

      S_MOVE: begin
        if (move_cnt_q != '0) begin
          move_cnt_d = move_cnt_q - 1'b1;
        end else begin
          if (dir_q == DIR_UP) begin
            nf   = (floor_q == 3'd7) ? 3'd7 : floor_q + 3'd1;
            stop = ccp_q[nf - 3'd1] | hall_up(hv, nf) | (nf == 3'd7) |
                   (!above_of(req, nf) & hall_dn(hv, nf));
          end else begin
            nf   = (floor_q == 3'd1) ? 3'd1 : floor_q - 3'd1;
            stop = ccp_q[nf - 3'd1] | hall_dn(hv, nf) | (nf == 3'd1) |
                   (!below_of(req, nf) & hall_up(hv, nf));
          end
          floor_d = nf;
          if (stop) begin
            state_d            = S_DOOR;
            door_cnt_d         = DOOR_LOAD;
            served_d           = hv & floor_mask(nf);
            ccp_d[nf - 3'd1]   = 1'b0;
          end else begin
            move_cnt_d = MOVE_LOAD;
          end
        end
      end

      S_DOOR: begin
        // Cabin presses for this floor are absorbed while the door is open.
        ccp_d[floor_q - 3'd1] = 1'b0;
        if (door_cnt_q != '0) begin
          door_cnt_d = door_cnt_q - 1'b1;
        end else begin
          // Moving down prefers below; moving up or entered from IDLE
          // prefers above. The current floor is not considered.
          state_d    = S_MOVE;
          move_cnt_d = MOVE_LOAD;
          if (dir_q == DIR_DN) begin
            if (below_of(req, floor_q))      dir_d = DIR_DN;
            else if (above_of(req, floor_q)) dir_d = DIR_UP;
            else begin state_d = S_IDLE; dir_d = DIR_STOP; move_cnt_d = '0; end
          end else begin
            if (above_of(req, floor_q))      dir_d = DIR_UP;
            else if (below_of(req, floor_q)) dir_d = DIR_DN;
            else begin state_d = S_IDLE; dir_d = DIR_STOP; move_cnt_d = '0; end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      floor_q    <= 3'd1;
      dir_q      <= DIR_STOP;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
      served_q   <= '0;
      ccp_q      <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
      served_q   <= served_d;
      ccp_q      <= ccp_d;
    end
  end

  assign currentFloor   = floor_q;
  assign direction      = dir_q;
  assign doorOpen       = (state_q == S_DOOR);
  assign servedButton   = served_q;
  assign carCallPending = ccp_q;

endmodule

// File: tb/tb_car_motion_controller.sv
module tb_car_motion_controller;
  localparam int M = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] hallButton;
  logic [6:0]  carButton;
  logic [2:0]  currentFloor;
  logic [1:0]  direction;
  logic        doorOpen;
  logic [13:0] servedButton;
  logic [6:0]  carCallPending;

  car_motion_controller #(.MOVE_CYCLES(M), .DOOR_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .hallButton(hallButton), .carButton(carButton),
    .currentFloor(currentFloor), .direction(direction), .doorOpen(doorOpen),
    .servedButton(servedButton), .carCallPending(carCallPending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: mode 0 idle, 1 moving, 2 door; dir +1/-1/0;
  // left = edges remaining until the next floor step / door close.
  int        m_mode, m_floor, m_dir, m_left;
  bit [6:0]  m_cab;
  bit [13:0] m_served;

  function automatic bit up_at(int f);
    return (f < 7) && hallButton[2*f-1];
  endfunction
  function automatic bit dn_at(int f);
    return (f > 1) && hallButton[2*f-2];
  endfunction
  function automatic bit req_at(int f);
    return m_cab[f-1] || up_at(f) || dn_at(f);
  endfunction
  function automatic bit any_req(int lo, int hi);
    for (int k = lo; k <= hi; k++) if (req_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit [6:0]  cab_n;
    bit [13:0] srv_n;
    int        f;
    bit        st;
    if (reset) begin
      m_mode = 0; m_floor = 1; m_dir = 0; m_left = 0; m_cab = '0; m_served = '0;
      return;
    end
    cab_n = m_cab | carButton;
    srv_n = '0;
    f = m_floor;
    case (m_mode)
      0: begin
        if (req_at(f)) begin
          m_mode = 2; m_left = D; cab_n[f-1] = 1'b0;
          if (up_at(f)) srv_n[2*f-1] = 1'b1;
          if (dn_at(f)) srv_n[2*f-2] = 1'b1;
        end else if (any_req(f+1, 7)) begin m_mode = 1; m_dir = 1;  m_left = M; end
        else if (any_req(1, f-1))     begin m_mode = 1; m_dir = -1; m_left = M; end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          f = m_floor + m_dir;
          m_floor = f;
          if (m_dir > 0) st = m_cab[f-1] || up_at(f) || f == 7 || (!any_req(f+1, 7) && dn_at(f));
          else           st = m_cab[f-1] || dn_at(f) || f == 1 || (!any_req(1, f-1) && up_at(f));
          if (st) begin
            m_mode = 2; m_left = D; cab_n[f-1] = 1'b0;
            if (up_at(f)) srv_n[2*f-1] = 1'b1;
            if (dn_at(f)) srv_n[2*f-2] = 1'b1;
          end else m_left = M;
        end
      end
      default: begin
        cab_n[f-1] = 1'b0;
        m_left--;
        if (m_left == 0) begin
          bit ab, be;
          ab = any_req(f+1, 7);
          be = any_req(1, f-1);
          if (m_dir < 0) begin
            if (be) m_dir = -1; else if (ab) m_dir = 1; else m_dir = 0;
          end else begin
            if (ab) m_dir = 1; else if (be) m_dir = -1; else m_dir = 0;
          end
          m_mode = (m_dir == 0) ? 0 : 1;
          m_left = M;
        end
      end
    endcase
    m_cab = cab_n;
    m_served = srv_n;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle, then the
  // upstream stage withdraws any hall calls just served.
  task automatic cyc();
    logic [1:0] ed;
    @(posedge clk);
    model_step();
    @(negedge clk);
    ed = (m_dir > 0) ? 2'b10 : (m_dir < 0) ? 2'b01 : 2'b00;
    tests++;
    if (currentFloor !== 3'(m_floor) || direction !== ed || doorOpen !== (m_mode == 2) ||
        servedButton !== m_served || carCallPending !== m_cab) begin
      fails++;
      if (fails < 25)
        $display("FAIL model t=%0t: got fl=%0d dir=%b door=%b srv=%h ccp=%b expected fl=%0d dir=%b door=%b srv=%h ccp=%b",
                 $time, currentFloor, direction, doorOpen, servedButton, carCallPending,
                 m_floor, ed, m_mode == 2, m_served, m_cab);
    end
    hallButton = hallButton & ~m_served;
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_car(logic [6:0] b);
    carButton = b;
    cyc();
    carButton = '0;
  endtask

  task automatic wait_door();
    for (int i = 0; i < 200; i++) begin
      if (doorOpen) return;
      cyc();
    end
    tests++; fails++;
    $display("FAIL wait_door: door still %b after 200 cycles, expected 1", doorOpen);
  endtask

  initial begin
    reset = 1'b1; hallButton = '0; carButton = '0;
    m_mode = 0; m_floor = 1; m_dir = 0; m_left = 0; m_cab = '0; m_served = '0;
    cycn(2);
    reset = 1'b0;
    chk("rst_floor", currentFloor, 1);
    chk("rst_dir", direction, 2'b00);
    chk("rst_door", doorOpen, 0);
    chk("rst_srv", servedButton, 0);
    chk("rst_ccp", carCallPending, 0);

    // Single cabin call to floor 3.
    pulse_car(7'b0000100);
    cyc();
    chk("t2_dir_up", direction, 2'b10);
    chk("t2_floor1", currentFloor, 1);
    cycn(4);
    chk("t2_floor2", currentFloor, 2);
    cycn(4);
    chk("t2_floor3", currentFloor, 3);
    chk("t2_door", doorOpen, 1);
    cycn(2);
    chk("t2_door_last", doorOpen, 1);
    cyc();
    chk("t2_closed", doorOpen, 0);
    chk("t2_idle_dir", direction, 2'b00);
    chk("t2_ccp", carCallPending, 0);

    // Request at the current floor.
    pulse_car(7'b0001000);
    wait_door();
    chk("t4_at4", currentFloor, 4);
    cycn(D);
    hallButton = 14'h0080;
    cyc();
    chk("t4_door", doorOpen, 1);
    chk("t4_srv", servedButton, 14'h0080);
    chk("t4_dir", direction, 2'b00);
    cycn(D);

    // Direction-aware stopping from floor 1.
    reset = 1'b1; cyc(); reset = 1'b0;
    hallButton = 14'h0210;
    wait_door();
    chk("t3_floor5", currentFloor, 5);
    chk("t3_srv5", servedButton, 14'h0200);
    chk("t3_dir_door", direction, 2'b10);
    cycn(D);
    chk("t3_reverse", direction, 2'b01);
    wait_door();
    chk("t3_floor3", currentFloor, 3);
    chk("t3_srv3", servedButton, 14'h0010);
    cycn(D);
    chk("t3_idle", direction, 2'b00);

    // Floor clamp at 7 and travel to 1.
    pulse_car(7'b1000000);
    wait_door();
    chk("t5_at7", currentFloor, 7);
    cycn(D);
    hallButton = 14'h2000;
    cycn(20);
    chk("t5_stay7", currentFloor, 7);
    chk("t5_stay_dir", direction, 2'b00);
    chk("t5_stay_door", doorOpen, 0);
    pulse_car(7'b0000001);
    cyc();
    chk("t5_dir_dn", direction, 2'b01);
    wait_door();
    chk("t5_at1", currentFloor, 1);
    cycn(D);
    hallButton = '0;

    // Simultaneous requests above and below.
    pulse_car(7'b0001000);
    wait_door();
    cycn(D);
    pulse_car(7'b0100010);
    cyc();
    chk("t6_dir_up", direction, 2'b10);
    wait_door();
    chk("t6_at6", currentFloor, 6);
    cycn(D);
    chk("t6_reverse", direction, 2'b01);
    wait_door();
    chk("t6_at2", currentFloor, 2);
    cycn(D);

    // Reset mid-move between floors 3 and 4.
    pulse_car(7'b1000000);
    for (int i = 0; i < 100 && currentFloor != 3'd3; i++) cyc();
    chk("t1_reach3", currentFloor, 3);
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t1_floor", currentFloor, 1);
    chk("t1_dir", direction, 2'b00);
    chk("t1_door", doorOpen, 0);
    chk("t1_ccp", carCallPending, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      carButton = ($urandom_range(0, 11) == 0) ? (7'd1 << $urandom_range(0, 6)) : 7'd0;
      if ($urandom_range(0, 9) == 0)  hallButton = hallButton | (14'd1 << $urandom_range(0, 13));
      if ($urandom_range(0, 39) == 0) hallButton = hallButton & ~(14'd1 << $urandom_range(0, 13));
      reset = ($urandom_range(0, 799) == 0);
      cyc();
    end
    reset = 1'b0; carButton = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/car_motion_controller.md
# car_motion_controller

Per-car motion and door controller for the 2-car, 7-floor elevator system. It sits directly downstream of the hall-call assignment stage. It consumes that stage's per-car hall-call vector plus the car's own in-cabin calls, and runs a SCAN (collective) policy. Each cycle it produces the car's `currentFloor`, `direction` and door state, which the assignment stage reads back as `currentFloorN`/`directionN`. On each stop it also emits a one-cycle served-call mask so served calls are cleared.

## Interface

Parameters:
- `MOVE_CYCLES`, default 8: clock cycles to travel one floor; legal values are ≥2.
- `DOOR_CYCLES`, default 6: clock cycles the door stays open per stop; legal values are ≥1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `hallButton`, input, 14: hall calls assigned to this car. Floor k (1..7) uses bits [2k-1:2k-2]: bit 2k-1 = UP, bit 2k-2 = DOWN. Bit 0 (DOWN at floor 1) and bit 13 (UP at floor 7) are ignored.
- `carButton`, input, 7: in-cabin call pulses; bit k-1 = floor k. Latched internally.
- `currentFloor`, output, 3: current floor, 3'd1..3'd7.
- `direction`, output, 2: STOP=2'b00, UP=2'b10, DOWN=2'b01. UPDOWN (2'b11) is never driven.
- `doorOpen`, output, 1: high while in state DOOR.
- `servedButton`, output, 14: one-cycle pulse of the hall bits served at a stop, in the same encoding as `hallButton`.
- `carCallPending`, output, 7: the latched cabin calls.

## Operation

- **Request sets.** The request vector is req[k] = carCallPending[k-1] OR either valid hall bit of floor k. `above` = OR of req for floors > currentFloor; `below` = OR of req for floors < currentFloor.
- **States.**
  - IDLE: `direction` = STOP.
  - MOVE: `direction` = UP or DOWN.
  - DOOR: `direction` holds its last non-STOP value, or STOP if the door was entered from IDLE.
- **IDLE transitions.**
  - req[currentFloor] → DOOR.
  - else `above` → MOVE, direction UP.
  - else `below` → MOVE, direction DOWN.
  - else stay in IDLE.
  - Priority is current floor > above > below.
- **MOVE.**
  - The move counter loads MOVE_CYCLES-1 on entry and decrements each cycle.
  - At 0, `currentFloor` steps ±1 and the car evaluates whether to stop at the new floor f.
- **Stop rule at floor f when moving UP.** Stop if any of the following holds:
  - carCall[f], or
  - hall UP at f, or
  - f == 7, or
  - no requests above f and hall DOWN at f.
- **Stop rule when moving DOWN.** Symmetric to the UP rule; f == 1 forces a stop.
- **Stop action.**
  - If the rule fires, go to DOOR.
  - If not, reload the counter and keep moving.
  - The floor never leaves the range 1..7.
- **DOOR.**
  - On entry: `servedButton` pulses both valid hall bits of the floor, ANDed with `hallButton` in that cycle. carCallPending[f-1] is cleared.
  - The door counter loads DOOR_CYCLES-1 and decrements.
  - At 0, the next state is chosen:
    - keep the same direction if requests remain ahead → MOVE;
    - else reverse if requests exist behind → MOVE in the opposite direction;
    - else → IDLE.
  - From DOOR entered via IDLE, next-state selection follows the IDLE priority, excluding the current floor.
- **Cabin-call latching.** carButton bits OR into carCallPending every cycle. A carButton bit for the current floor that arrives while in DOOR is absorbed, i.e. cleared the same cycle.
- **Hall-call changes.** Hall calls appearing or vanishing mid-move take effect at the next floor evaluation.

## Timing

- **Reset values.** `currentFloor` = 1, `direction` = STOP, `doorOpen` = 0, `servedButton` = 0, `carCallPending` = 0. State = IDLE and both counters = 0. Reset asserted mid-move or mid-door takes effect on the next edge; there is no partial-floor state.
- **Idle to move.** With a request present in IDLE, MOVE (or DOOR) is entered on the next edge. `direction` is registered and changes on that same edge.
- **Per-floor travel.** Each floor step occurs exactly MOVE_CYCLES cycles after MOVE entry or after the previous step.
- **Arrival.** DOOR is entered on the same edge as the final floor step. `doorOpen` rises and `servedButton` is valid for exactly that one cycle.
- **Door dwell.** `doorOpen` stays high for exactly DOOR_CYCLES cycles.
- **Registered outputs.** All outputs are registered; there is no combinational input→output path.

## Test plan

1. **Reset mid-move.** Assert reset while the car is in MOVE between floors 3 and 4 → next cycle `currentFloor` = 1, `direction` = 00, `doorOpen` = 0, `carCallPending` = 0.
2. **Single cabin call, MOVE_CYCLES=4, DOOR_CYCLES=3.** From floor 1 in IDLE, pulse carButton = 7'b0000100 → `direction` = 10 at the next edge. Floor 2 is reached 4 cycles later and floor 3 8 cycles later. `doorOpen` = 1 for 3 cycles, then IDLE with `direction` = 00 and carCallPending = 0.
3. **Direction-aware stopping.** Car moving UP from floor 1 with hallButton DOWN at floor 3 (bit 4) and UP at floor 5 (bit 9) → passes floor 3 without stopping, stops at 5 with servedButton = 14'h0200. It then reverses, stops at 3 with servedButton = 14'h0010, then goes IDLE.
4. **Request at the current floor.** Car in IDLE at floor 4, hall UP at floor 4 asserted (bit 7) → DOOR next edge, servedButton = 14'h0080, `direction` stays 00.
5. **Floor clamp.** Car at floor 7 with only the invalid bit 13 set → remains in IDLE and never exceeds floor 7. A cabin call to floor 1 while at 7 → DOWN travel that stops at 1.
6. **Simultaneous requests.** In IDLE at floor 4, requests at floors 6 and 2 arrive in the same cycle → `direction` = UP (above wins). After serving floor 6 the car reverses to serve floor 2.
